// File: rtl/codec_cfg_sequencer.sv
// Table-driven WM8731 register-write sequencer feeding the i2cgenerator byte engine.
// Each mode owns a STEPS-deep slice of a runtime-writable word table; words stream out over load/ready.
module codec_cfg_sequencer #(
  parameter int unsigned MODES     = 4,
  parameter int unsigned STEPS     = 4,
  parameter bit          AUTO_INIT = 1'b1,
  parameter int unsigned MW        = $clog2(MODES),
  parameter int unsigned AW        = $clog2(MODES * STEPS)
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          req,
  input  logic [MW-1:0] mode,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [16:0]   tbl_wdata,
  input  logic          ready,
  output logic          load,
  output logic [15:0]   data,
  output logic          busy,
  output logic          done,
  output logic [MW-1:0] cur_mode,
  output logic          overrun,
  output logic [7:0]    words_sent
);

  localparam int unsigned DEPTH = MODES * STEPS;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [16:0]   tbl [DEPTH];
  logic [AW-1:0] ptr_q;
  logic [SW-1:0] step_q;
  logic          last_q;
  logic          init_q;
  logic          pend_valid_q;
  logic [MW-1:0] pend_mode_q;

  logic          start;
  logic [MW-1:0] start_mode;
  logic [MW-1:0] req_mode;
  logic          slot_consume;
  logic          req_direct;
  logic          req_to_slot;
  logic          advance;

  // Power-up contents: mode 0 = reset, mode 1 = loopback, mode 2 = silence.
  function automatic logic [16:0] tbl_default(input int unsigned idx);
    logic [16:0] w;
    w = 17'h1_0000;
    if (idx == 0)                  w = {1'b1, 7'h0F, 9'h000};
    else if (idx == STEPS)         w = {1'b0, 7'h06, 9'h00E};
    else if (idx == STEPS + 1)     w = {1'b1, 7'h04, 9'h00A};
    else if (idx == 2 * STEPS)     w = {1'b0, 7'h04, 9'h002};
    else if (idx == 2 * STEPS + 1) w = {1'b1, 7'h06, 9'h09F};
    return w;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    start_mode   = '0;
    slot_consume = 1'b0;
    load         = 1'b0;
    done         = 1'b0;
    advance      = 1'b0;
    req_mode     = (32'(mode) >= 32'(MODES)) ? '0 : mode;

    case (state_q)
      S_IDLE: begin
        if (init_q) begin
          start = 1'b1;
        end else if (pend_valid_q) begin
          start        = 1'b1;
          start_mode   = pend_mode_q;
          slot_consume = 1'b1;
        end else if (req) begin
          start      = 1'b1;
          start_mode = req_mode;
        end
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (ready) begin
          load    = 1'b1;
          state_d = S_GAP;
        end
      end
      // Generator drops ready one cycle after load; don't trust it here.
      S_GAP: state_d = S_WAIT;
      S_WAIT: begin
        if (ready) begin
          if (last_q || step_q == SW'(STEPS - 1)) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            advance = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_direct  = (state_q == S_IDLE) && !init_q && !pend_valid_q;
    req_to_slot = req && !req_direct;
    overrun     = req_to_slot && pend_valid_q && !slot_consume;
    busy        = (state_q != S_IDLE);
  end

  // Sequence datapath and request slot.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ptr_q        <= '0;
      step_q       <= '0;
      last_q       <= 1'b0;
      data         <= 16'h0000;
      cur_mode     <= '0;
      words_sent   <= 8'd0;
      pend_valid_q <= 1'b0;
      pend_mode_q  <= '0;
      init_q       <= AUTO_INIT;
    end else begin
      init_q <= 1'b0;
      if (start) begin
        ptr_q    <= AW'(32'(start_mode) * STEPS);
        step_q   <= '0;
        cur_mode <= start_mode;
      end
      if (state_q == S_FETCH) begin
        data   <= tbl[ptr_q][15:0];
        last_q <= tbl[ptr_q][16];
      end
      if (load) words_sent <= words_sent + 8'd1;
      if (advance) begin
        ptr_q  <= ptr_q + AW'(1);
        step_q <= step_q + SW'(1);
      end
      if (req_to_slot) begin
        pend_valid_q <= 1'b1;
        pend_mode_q  <= req_mode;
      end else if (slot_consume) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Word table; a same-cycle fetch sees the pre-write value.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= tbl_default(i);
    end else if (tbl_we && 32'(tbl_addr) < 32'(DEPTH)) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

endmodule
